// File: rtl/alu_cmd_sequencer.sv
// Command/response front end for the registered 4-bit ALU wrapper.
// Commands drive the wrapper from registers, a valid-bit tracker follows each
// one through the wrapper latency, and results land in an in-order response
// FIFO. Credits (in-flight + buffered < DEPTH) guarantee a capture always has room.
module alu_cmd_sequencer #(
  parameter int unsigned ALU_LAT = 2,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [2:0]       cmd_op,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_op,
  input  logic [3:0]       alu_result,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [3:0]       rsp_result,
  output logic             rsp_carry,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(DEPTH + ALU_LAT + 2);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef struct packed {
    logic [3:0]       result;
    logic             carry;
    logic [TAG_W-1:0] tag;
  } rsp_ent_t;

  logic [ALU_LAT:0] pipe_vld;
  logic [TAG_W-1:0] pipe_tag [ALU_LAT+1];
  logic [TAG_W-1:0] tag_cnt;
  rsp_ent_t         mem [DEPTH];
  rsp_ent_t         head;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] fifo_count;
  logic [CNT_W-1:0] inflight;
  logic             accept;
  logic             push;
  logic             pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Count of commands still travelling through the wrapper.
  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i <= ALU_LAT; i++) begin
      inflight = inflight + CNT_W'(pipe_vld[i]);
    end
  end

  assign cmd_ready = (inflight + fifo_count) < CNT_W'(DEPTH);
  assign accept    = cmd_valid && cmd_ready;
  assign push      = pipe_vld[ALU_LAT];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign busy      = (pipe_vld != '0) || (fifo_count != '0);

  assign head       = mem[rd_ptr];
  assign rsp_result = head.result;
  assign rsp_carry  = head.carry;
  assign rsp_tag    = head.tag;

  // Operand registers feeding the wrapper; hold when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a  <= '0;
      alu_b  <= '0;
      alu_op <= '0;
    end else if (accept) begin
      alu_a  <= cmd_a;
      alu_b  <= cmd_b;
      alu_op <= cmd_op;
    end
  end

  // Sequence tag stamped on each accepted command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_cnt <= '0;
    end else if (accept) begin
      tag_cnt <= tag_cnt + TAG_W'(1);
    end
  end

  // Latency tracker: valid bits and tags shift one stage every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int unsigned i = 0; i <= ALU_LAT; i++) begin
        pipe_tag[i] <= '0;
      end
    end else begin
      pipe_vld[0] <= accept;
      pipe_tag[0] <= tag_cnt;
      for (int unsigned i = 1; i <= ALU_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // Response FIFO: capture at the tracker tail, pop on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{result: alu_result, carry: alu_carry, tag: pipe_tag[ALU_LAT]};
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
- Command/response front end for the registered 4-bit ALU wrapper.
- Accepts operand/op commands over a valid/ready handshake and drives the wrapper's a/b/op inputs from registers.
- Tracks each command through the wrapper's fixed pipeline latency and captures result/carry into a response FIFO. Responses leave over a valid/ready handshake, in order, tagged.
- Credit-based flow control: no captured result is ever dropped.

Parameters:
- ALU_LAT, 2: clock edges from an alu_a/alu_b/alu_op change to alu_result/alu_carry holding the corresponding value (wrapper input reg + output reg).
- DEPTH, 4: response FIFO entries. Also the cap on in-flight plus buffered commands. Must be ≥1.
- TAG_W, 2: width of the sequence tag attached to each command.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset; shared with the wrapper.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at a rising edge.
- cmd_a  input  4  operand a.
- cmd_b  input  4  operand b.
- cmd_op  input  3  ALU opcode, passed through unchanged.
- alu_a  output  4  to wrapper a.
- alu_b  output  4  to wrapper b.
- alu_op  output  3  to wrapper op.
- alu_result  input  4  from wrapper result.
- alu_carry  input  1  from wrapper carry.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  consumer takes response at edge when rsp_valid && rsp_ready.
- rsp_result  output  4  captured result.
- rsp_carry  output  1  captured carry.
- rsp_tag  output  TAG_W  tag of the originating command.
- busy  output  1  any command in flight or buffered.

Behaviour:
- Reset (asynchronous, rst_n low):
  - alu_a=0, alu_b=0, alu_op=0.
  - Pipe tracker, FIFO pointers/count and tag counter cleared.
  - rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_tag=0, busy=0.
  - cmd_ready=1 once rst_n is high (DEPTH≥1).
- Issue: at edge E with cmd_valid && cmd_ready:
  - alu_a/alu_b/alu_op <= cmd fields.
  - pipe[0] <= 1 and the entry is stamped with tag_cnt; tag_cnt increments, wrapping at 2^TAG_W-1 -> 0.
  - With no accept, alu_* hold their last value and pipe[0] <= 0.
- Tracker: shift register pipe[0..ALU_LAT] of valid bits plus a parallel tag shift register. It shifts every edge.
- Capture: at any edge where pipe[ALU_LAT]=1, write {alu_result, alu_carry, tag} into the FIFO tail.
  - With ALU_LAT=2: accept at E -> wrapper samples at E+1 -> result registered at E+2 -> captured at E+3.
  - rsp_valid rises after E+3 when the FIFO was empty.
- Back-to-back: one command per cycle sustained; captures occur on consecutive edges.
- Credit: cmd_ready = (popcount(pipe) + fifo_count) < DEPTH. It is combinational from registers only, with no path from cmd_valid or rsp_ready.
  - A capture can therefore never find the FIFO full.
- FIFO:
  - Registered head drives rsp_*; rsp_valid = (fifo_count != 0).
  - rsp_* hold stable while rsp_valid && !rsp_ready.
  - Capture and pop on the same edge: count unchanged, ordering preserved.
  - Capture into an empty FIFO with simultaneous pop is impossible, since rsp_valid=0.
  - Pop when empty is ignored.
- Ordering: responses leave strictly in acceptance order; rsp_tag increments by 1 mod 2^TAG_W between consecutive responses.
- busy = (pipe != 0) || (fifo_count != 0).
- Reset mid-operation: all in-flight and buffered commands are discarded; no response is produced for them after release. The tag restarts at 0.
- Arithmetic: none internally; result/carry pass through bit-exact. Counters are sized ⌈log2(DEPTH+ALU_LAT+2)⌉.

Test Plan (wrapper replaced by a stub with identical register structure, computing result=(a+b)[3:0], carry=(a+b)[4]):
- Single command a=4'h9, b=4'h8 accepted at edge E -> rsp_valid high after E+3 with rsp_result=4'h1, rsp_carry=1, rsp_tag=0; busy low after pop.
- Four back-to-back commands (1,2), (3,4), (15,1), (7,7) with rsp_ready=1 -> responses on four consecutive cycles: {3,0,t0}, {7,0,t1}, {0,1,t2}, {14,0,t3}.
- rsp_ready=0 with commands offered every cycle -> cmd_ready drops after exactly 4 accepts. No loss: releasing rsp_ready yields all 4 in order, and cmd_ready reasserts the cycle after the first pop.
- Five commands, then rsp_ready toggled 1/0 every cycle -> tags 0,1,2,3,0 in order; rsp_* stable during stall cycles.
- rst_n pulsed low 1 cycle after two accepts -> rsp_valid=0, busy=0, alu_*=0 immediately. The next command after release returns rsp_tag=0 with its own result only.
- Capture and pop on the same edge with fifo_count=2 -> count stays 2, the next three responses are in order.
